// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU request / CDB broadcast bundle for the CDB arbiter
interface cdb_arbiter_if #(
    parameter int FU_NUM    = 8,
    parameter int FU_INDEX  = 3,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4
);
    logic [FU_NUM-1:0]           req;
    logic [FU_NUM*WORD_SIZE-1:0] req_data;
    logic [FU_NUM*RB_INDEX-1:0]  req_rb_index;
    logic                        cdb_stall;
    logic                        flush;
    logic [FU_NUM-1:0]           grant;
    logic                        cdb_valid;
    logic [WORD_SIZE-1:0]        cdb_data;
    logic [RB_INDEX-1:0]         cdb_rb_index;
    logic [FU_INDEX-1:0]         cdb_fu_id;

    // master: the arbiter; slave: the FUs and CDB consumers around it
    modport master (
        input  req, req_data, req_rb_index, cdb_stall, flush,
        output grant, cdb_valid, cdb_data, cdb_rb_index, cdb_fu_id
    );

    modport slave (
        output req, req_data, req_rb_index, cdb_stall, flush,
        input  grant, cdb_valid, cdb_data, cdb_rb_index, cdb_fu_id
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered common data bus
module cdb_arbiter #(
    parameter int FU_NUM    = 8,
    parameter int FU_INDEX  = 3,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.master bus
);
    localparam logic [RB_INDEX-1:0] RB_NULL   = '1;
    localparam logic [FU_INDEX-1:0] PTR_RESET = FU_INDEX'(FU_NUM - 1);

    logic [FU_NUM-1:0]    grant_q;
    logic                 valid_q;
    logic [WORD_SIZE-1:0] data_q;
    logic [RB_INDEX-1:0]  rb_q;
    logic [FU_INDEX-1:0]  fu_q;
    logic [FU_INDEX-1:0]  last_ptr;

    logic [WORD_SIZE-1:0] fu_data [FU_NUM];
    logic [RB_INDEX-1:0]  fu_rb   [FU_NUM];
    logic [FU_NUM-1:0]    eligible;

    logic                 found;
    logic [FU_INDEX-1:0]  winner;
    logic [FU_NUM-1:0]    win_onehot;
    logic [WORD_SIZE-1:0] win_data;
    logic [RB_INDEX-1:0]  win_rb;

    // The FU currently on the bus is masked so it cannot win twice while it drops req.
    for (genvar i = 0; i < FU_NUM; i++) begin : g_unpack
        assign fu_data[i]  = bus.req_data[i*WORD_SIZE +: WORD_SIZE];
        assign fu_rb[i]    = bus.req_rb_index[i*RB_INDEX +: RB_INDEX];
        assign eligible[i] = bus.req[i] && (fu_rb[i] != RB_NULL) && !grant_q[i];
    end

    always_comb begin
        int                  idx;
        logic [FU_INDEX-1:0] sel;
        found      = 1'b0;
        winner     = '0;
        win_onehot = '0;
        win_data   = '0;
        win_rb     = '0;
        idx        = 0;
        sel        = '0;
        for (int k = 1; k <= FU_NUM; k++) begin
            idx = int'(last_ptr) + k;
            if (idx >= FU_NUM) begin
                idx = idx - FU_NUM;
            end
            sel = FU_INDEX'(idx);
            if (!found && eligible[sel]) begin
                found           = 1'b1;
                winner          = sel;
                win_onehot[sel] = 1'b1;
                win_data        = fu_data[sel];
                win_rb          = fu_rb[sel];
            end
        end
    end

    // Flush and stall both idle the bus but keep the last broadcast fields and pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            rb_q     <= '0;
            fu_q     <= '0;
            last_ptr <= PTR_RESET;
        end else if (bus.flush || bus.cdb_stall || !found) begin
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            grant_q  <= win_onehot;
            valid_q  <= 1'b1;
            data_q   <= win_data;
            rb_q     <= win_rb;
            fu_q     <= winner;
            last_ptr <= winner;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.cdb_valid    = valid_q;
    assign bus.cdb_data     = data_q;
    assign bus.cdb_rb_index = rb_q;
    assign bus.cdb_fu_id    = fu_q;
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the functional units in the Tomasulo core. Each cycle it selects at most one requesting FU and broadcasts that FU's result word and reorder-buffer (RB) index on a registered CDB port. The port feeds the CDB data controller, the reservation stations and the reorder buffer. Requesting FUs hold their result until granted, which gives them back-pressure.

## Interface
- FU_NUM, 8, number of requesting functional units
- FU_INDEX, 3, width of an FU id (log2 FU_NUM)
- WORD_SIZE, 32, result word width
- RB_INDEX, 4, RB slot index width; all-ones value is NULL (no slot)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  FU_NUM  bit i: FU i has a result pending
- req_data  in  FU_NUM*WORD_SIZE  FU i result at bits [i*WORD_SIZE +: WORD_SIZE]
- req_rb_index  in  FU_NUM*RB_INDEX  FU i destination slot at bits [i*RB_INDEX +: RB_INDEX]
- cdb_stall  in  1  consumer cannot accept a broadcast this edge
- flush  in  1  branch-mispredict flush
- grant  out  FU_NUM  one-hot, registered; bit i high for exactly the cycle FU i's result is on the CDB
- cdb_valid  out  1  CDB carries a valid result
- cdb_data  out  WORD_SIZE  broadcast result
- cdb_rb_index  out  RB_INDEX  broadcast RB slot
- cdb_fu_id  out  FU_INDEX  id of the broadcasting FU

## Operation
- Eligible FU i: req[i]=1, its RB index is not NULL, and grant[i]=0 in the current cycle. The last condition masks the FU that is already being broadcast and prevents a double grant while it drops req.
- Round-robin pointer last_ptr (FU_INDEX bits). The search starts at last_ptr+1 and runs upward, wrapping from FU_NUM-1 to 0. The first eligible FU wins.
- On a rising edge, evaluated in priority order:
  - reset: grant=0, cdb_valid=0, cdb_data=0, cdb_rb_index=0, cdb_fu_id=0, last_ptr=FU_NUM-1 (so FU0 has top priority after reset).
  - flush: grant=0 and cdb_valid=0. cdb_data, cdb_rb_index and cdb_fu_id are held. last_ptr is unchanged. Requests present at this edge are ignored.
  - cdb_stall: grant=0 and cdb_valid=0. Data fields and last_ptr are held.
  - Winner w exists: grant=1<<w, cdb_valid=1, cdb_data=req_data[w], cdb_rb_index=req_rb_index[w], cdb_fu_id=w, last_ptr=w.
  - No winner: grant=0 and cdb_valid=0. Data fields and last_ptr are held.
- FU protocol: req, req_data and req_rb_index stay stable until the FU observes grant[i]=1. The FU then deasserts req, or presents its next result, at the edge ending the grant cycle.
- Requests with a NULL RB index are never granted and never move last_ptr.
- Width rules:
  - Pointer increment is modulo FU_NUM, with no out-of-range id when FU_NUM is a power of two.
  - Index extraction uses the explicit slices above.

## Timing
- Request-to-broadcast latency: 1 cycle. req sampled at edge t; cdb_valid, grant and the data fields are valid throughout cycle t+1.
- Throughput: one broadcast per cycle when distinct FUs are eligible.
- A single FU requesting continuously is granted at most every other cycle because of the grant mask.
- Fairness: a continuously eligible FU is granted within FU_NUM broadcast cycles.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.
- Reset or flush asserted mid-broadcast clears cdb_valid and grant at that edge. An FU that never saw its grant keeps requesting and is re-arbitrated once flush or reset deasserts.

## Test plan
- Reset: hold reset 2 cycles with all req=1 -> grant=0, cdb_valid=0, all data outputs 0. The first post-reset grant goes to FU0.
- Single request: FU2 with data=0xDEADBEEF, index=5, held 2 cycles -> one cycle with grant=8'h04, cdb_valid=1, cdb_data=0xDEADBEEF, cdb_rb_index=5, cdb_fu_id=2. No second grant follows.
- Full contention: all 8 FUs request from reset, each dropping req after its grant -> grants 0x01, 0x02, ..., 0x80 in 8 consecutive cycles, then cdb_valid=0.
- Rotation: after FU3 is granted, FU1 and FU5 request together -> FU5 is granted first, then FU1 on the next cycle.
- NULL index: FU4 requests with index=4'hF for 5 cycles -> never granted, last_ptr unchanged. FU6 with index 2 in the same window is granted normally.
- Stall/flush: FU1 requests and cdb_stall=1 for 3 cycles -> no grant. The stall drops and FU1 is granted on the next cycle. Flush asserted during FU0's grant cycle -> next cycle cdb_valid=0, and FU0 is not re-granted unless it still requests.
